// File: rtl/reed_period_meter.sv
// rtl/reed_period_meter.sv - reed contact period meter with bounce lockout and stop detect
module reed_period_meter #(
    parameter int LOCKOUT = 64,
    parameter int TIMEOUT = 16384
) (
    input  logic        CLK2048,
    input  logic        reset,
    input  logic        REED,
    output logic [14:0] PERIOD,
    output logic        PERIOD_VALID,
    output logic        REV_PULSE,
    output logic [15:0] REV_COUNT,
    output logic        STOPPED
);

    typedef enum logic [1:0] {
        ST_STOP = 2'd0,
        ST_ARM  = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    localparam logic [14:0] CNT_MAX = 15'h7FFF;
    localparam logic [14:0] LOCK_M1 = 15'(LOCKOUT - 1);
    localparam logic [14:0] TIME_M1 = 15'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic        s1_q, s1_d;
    logic        s2_q, s2_d;
    logic        s3_q, s3_d;
    logic [14:0] cnt_q, cnt_d;
    logic [14:0] period_q, period_d;
    logic        period_valid_q, period_valid_d;
    logic        rev_pulse_q, rev_pulse_d;
    logic [15:0] rev_count_q, rev_count_d;
    logic        stopped_q, stopped_d;
    logic        raw_edge;

    // s1 is the metastability catcher; the edge is taken one stage later
    assign raw_edge = s2_q & ~s3_q;

    // Next-state and output logic: lockout, period capture and timeout
    always_comb begin
        s1_d           = REED;
        s2_d           = s1_q;
        s3_d           = s2_q;
        state_d        = state_q;
        cnt_d          = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 15'd1;
        period_d       = period_q;
        period_valid_d = 1'b0;
        rev_pulse_d    = 1'b0;
        rev_count_d    = rev_count_q;
        stopped_d      = stopped_q;
        case (state_q)
            ST_STOP: begin
                // First edge after a stop only starts timing; no period yet
                if (raw_edge) begin
                    cnt_d       = 15'd0;
                    state_d     = ST_ARM;
                    stopped_d   = 1'b0;
                    rev_pulse_d = 1'b1;
                    rev_count_d = rev_count_q + 16'd1;
                end
            end
            ST_ARM, ST_RUN: begin
                // An accepted edge takes priority over the timeout on the same cycle
                if (raw_edge && (cnt_q >= LOCK_M1)) begin
                    period_d       = cnt_q + 15'd1;
                    period_valid_d = 1'b1;
                    rev_pulse_d    = 1'b1;
                    rev_count_d    = rev_count_q + 16'd1;
                    cnt_d          = 15'd0;
                    state_d        = ST_RUN;
                end else if (cnt_q == TIME_M1) begin
                    state_d   = ST_STOP;
                    stopped_d = 1'b1;
                end
            end
            default: begin
                state_d   = ST_STOP;
                stopped_d = 1'b1;
            end
        endcase
    end

    // State and output registers, asynchronously cleared
    always_ff @(posedge CLK2048 or posedge reset) begin
        if (reset) begin
            state_q        <= ST_STOP;
            s1_q           <= 1'b0;
            s2_q           <= 1'b0;
            s3_q           <= 1'b0;
            cnt_q          <= 15'd0;
            period_q       <= 15'd0;
            period_valid_q <= 1'b0;
            rev_pulse_q    <= 1'b0;
            rev_count_q    <= 16'd0;
            stopped_q      <= 1'b1;
        end else begin
            state_q        <= state_d;
            s1_q           <= s1_d;
            s2_q           <= s2_d;
            s3_q           <= s3_d;
            cnt_q          <= cnt_d;
            period_q       <= period_d;
            period_valid_q <= period_valid_d;
            rev_pulse_q    <= rev_pulse_d;
            rev_count_q    <= rev_count_d;
            stopped_q      <= stopped_d;
        end
    end

    assign PERIOD       = period_q;
    assign PERIOD_VALID = period_valid_q;
    assign REV_PULSE    = rev_pulse_q;
    assign REV_COUNT    = rev_count_q;
    assign STOPPED      = stopped_q;

endmodule

// File: tb/tb_reed_period_meter.sv
// tb/tb_reed_period_meter.sv - scoreboard bench for reed_period_meter
module tb_reed_period_meter;

    localparam int LOCKOUT = 64;
    localparam int TIMEOUT = 16384;

    logic        clk;
    logic        reset;
    logic        REED;
    logic [14:0] PERIOD;
    logic        PERIOD_VALID;
    logic        REV_PULSE;
    logic [15:0] REV_COUNT;
    logic        STOPPED;

    reed_period_meter #(.LOCKOUT(LOCKOUT), .TIMEOUT(TIMEOUT)) dut (
        .CLK2048      (clk),
        .reset        (reset),
        .REED         (REED),
        .PERIOD       (PERIOD),
        .PERIOD_VALID (PERIOD_VALID),
        .REV_PULSE    (REV_PULSE),
        .REV_COUNT    (REV_COUNT),
        .STOPPED      (STOPPED)
    );

    typedef struct {
        int          cyc;
        bit          stop;
        bit          pv;
        logic [14:0] period;
        logic [15:0] rev;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   prev_stopped = 1'b1;

    // Reference model state, advanced when stimulus is driven
    bit          m_running = 1'b0;
    int          m_last = 0;
    logic [14:0] m_period = 15'd0;
    logic [15:0] m_rev = 16'd0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    // Edge driven at negedge c is sampled at posedge c+1 and appears at posedge c+3
    task automatic model_edge(input int c);
        exp_t e;
        int   o;
        o = c + 3;
        if (!m_running) begin
            m_rev     = m_rev + 16'd1;
            m_running = 1'b1;
            m_last    = o;
            e = '{cyc: o, stop: 1'b0, pv: 1'b0, period: m_period, rev: m_rev};
            sb.push_back(e);
        end else if (o - m_last >= LOCKOUT) begin
            m_period = 15'(o - m_last);
            m_rev    = m_rev + 16'd1;
            m_last   = o;
            e = '{cyc: o, stop: 1'b0, pv: 1'b1, period: m_period, rev: m_rev};
            sb.push_back(e);
        end
    endtask

    task automatic model_quiet();
        exp_t e;
        if (m_running) begin
            e = '{cyc: m_last + TIMEOUT, stop: 1'b1, pv: 1'b0, period: m_period, rev: m_rev};
            sb.push_back(e);
            m_running = 1'b0;
        end
    endtask

    task automatic pulse();
        @(negedge clk);
        REED = 1'b1;
        model_edge(cyc);
        @(negedge clk);
        REED = 1'b0;
    endtask

    // Idle so that the next pulse starts p cycles after the previous one started
    task automatic gap(input int p);
        repeat (p - 2) @(negedge clk);
    endtask

    // Scoreboard consumer: every strobe or STOPPED rise must match the next expectation
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            prev_stopped = STOPPED;
        end else begin
            if (REV_PULSE || PERIOD_VALID || (STOPPED && !prev_stopped)) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_event cyc=%0d rev_pulse=%b period_valid=%b stopped=%b",
                             cyc, REV_PULSE, PERIOD_VALID, STOPPED);
                end else begin
                    e = sb.pop_front();
                    checks++;
                    if (cyc !== e.cyc) begin
                        errors++;
                        $display("FAIL event_cycle got %0d expected %0d", cyc, e.cyc);
                    end
                    checks++;
                    if (REV_PULSE !== !e.stop) begin
                        errors++;
                        $display("FAIL rev_pulse cyc=%0d got %b expected %b", cyc, REV_PULSE, !e.stop);
                    end
                    checks++;
                    if (PERIOD_VALID !== e.pv) begin
                        errors++;
                        $display("FAIL period_valid cyc=%0d got %b expected %b", cyc, PERIOD_VALID, e.pv);
                    end
                    checks++;
                    if (PERIOD !== e.period) begin
                        errors++;
                        $display("FAIL period cyc=%0d got %0d expected %0d", cyc, PERIOD, e.period);
                    end
                    checks++;
                    if (REV_COUNT !== e.rev) begin
                        errors++;
                        $display("FAIL rev_count cyc=%0d got %0d expected %0d", cyc, REV_COUNT, e.rev);
                    end
                    checks++;
                    if (STOPPED !== e.stop) begin
                        errors++;
                        $display("FAIL stopped cyc=%0d got %b expected %b", cyc, STOPPED, e.stop);
                    end
                end
            end
            prev_stopped = STOPPED;
        end
    end

    // Asynchronous reset mid-cycle; outputs must clear before any clock edge
    task automatic apply_reset(input string name);
        @(negedge clk);
        #2 reset = 1'b1;
        REED = 1'b0;
        #1;
        checks++;
        if (PERIOD !== 15'd0) begin
            errors++; $display("FAIL %s_period got %0d expected 0", name, PERIOD);
        end
        checks++;
        if (PERIOD_VALID !== 1'b0 || REV_PULSE !== 1'b0) begin
            errors++; $display("FAIL %s_strobes got %b%b expected 00", name, PERIOD_VALID, REV_PULSE);
        end
        checks++;
        if (REV_COUNT !== 16'd0) begin
            errors++; $display("FAIL %s_rev_count got %0d expected 0", name, REV_COUNT);
        end
        checks++;
        if (STOPPED !== 1'b1) begin
            errors++; $display("FAIL %s_stopped got %b expected 1", name, STOPPED);
        end
        checks++;
        if (sb.size() != 0) begin
            errors++; $display("FAIL %s_pending got %0d expected 0", name, sb.size());
            sb.delete();
        end
        m_running = 1'b0;
        m_period  = 15'd0;
        m_rev     = 16'd0;
        @(negedge clk);
        #2 reset = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset("reset");
    endtask

    task automatic test_train_157();
        for (int i = 0; i < 5; i++) begin
            pulse();
            gap(157);
        end
    endtask

    task automatic test_train_1kmh();
        for (int i = 0; i < 2; i++) begin
            gap(15329);
            pulse();
        end
        repeat (10) @(negedge clk);
        checks++;
        if (STOPPED !== 1'b0) begin
            errors++; $display("FAIL kmh_stopped got %b expected 0", STOPPED);
        end
    endtask

    task automatic test_reset_mid();
        gap(200);
        pulse();
        repeat (100) @(negedge clk);
        apply_reset("reset_mid");
        pulse();
        gap(300);
        pulse();
        repeat (10) @(negedge clk);
    endtask

    task automatic test_bounce();
        apply_reset("bounce_reset");
        pulse();
        gap(5);
        pulse();
        gap(35);
        pulse();
        gap(160);
        pulse();
        repeat (10) @(negedge clk);
    endtask

    task automatic test_timeout();
        logic [14:0] held;
        pulse();
        gap(300);
        pulse();
        held = m_period;
        model_quiet();
        repeat (TIMEOUT + 20) @(negedge clk);
        checks++;
        if (STOPPED !== 1'b1 || PERIOD !== held) begin
            errors++;
            $display("FAIL timeout_hold got stopped=%b period=%0d expected stopped=1 period=%0d",
                     STOPPED, PERIOD, held);
        end
        // Next edge restarts; an edge exactly TIMEOUT cycles later beats the timeout
        pulse();
        gap(TIMEOUT);
        pulse();
        repeat (10) @(negedge clk);
        checks++;
        if (STOPPED !== 1'b0 || PERIOD !== 15'(TIMEOUT)) begin
            errors++;
            $display("FAIL timeout_edge got stopped=%b period=%0d expected stopped=0 period=%0d",
                     STOPPED, PERIOD, TIMEOUT);
        end
    endtask

    task automatic test_wrap();
        apply_reset("wrap_reset");
        pulse();
        repeat (10) @(negedge clk);
        force dut.rev_count_q = 16'hFFFF;
        @(posedge clk);
        #1 release dut.rev_count_q;
        m_rev = 16'hFFFF;
        repeat (80) @(negedge clk);
        pulse();
        repeat (10) @(negedge clk);
        checks++;
        if (REV_COUNT !== 16'd0) begin
            errors++; $display("FAIL wrap_count got %0d expected 0", REV_COUNT);
        end
    endtask

    initial begin
        reset = 1'b1;
        REED  = 1'b0;
        test_reset();
        test_train_157();
        test_train_1kmh();
        test_reset_mid();
        test_bounce();
        test_timeout();
        test_wrap();
        repeat (5) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++; $display("FAIL scoreboard_drain got %0d pending expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
